// File: rtl/inc_sequencer_pkg.sv
// Shared definitions for the incrementer sequencer: FSM state encoding and
// operand-select codes.
package inc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/inc_sequencer_if.sv
// Request/result handshake bundle between a requester and inc_sequencer.
// The master drives requests and consumes results; the slave is the sequencer.
interface inc_sequencer_if #(
    parameter int N     = 4,
    parameter int CNT_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_sel;
    logic [N-1:0]     req_a;
    logic [N-1:0]     req_b;
    logic [CNT_W-1:0] req_count;
    logic             abort;
    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     res_y;
    logic             res_cout;
    logic             res_zero;
    logic             busy;

    modport master (
        output req_valid, req_sel, req_a, req_b, req_count, abort, res_ready,
        input  req_ready, res_valid, res_y, res_cout, res_zero, busy
    );

    modport slave (
        input  req_valid, req_sel, req_a, req_b, req_count, abort, res_ready,
        output req_ready, res_valid, res_y, res_cout, res_zero, busy
    );

endinterface

// File: rtl/inc_sequencer_inc_unit.sv
// Combinational N-bit incrementer: y = a + 1 with carry-out, built as a
// half-adder ripple chain with the carry-in tied high.
module inc_unit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] y,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign y[gi]         = a[gi] ^ carry[gi];
            assign carry[gi + 1] = a[gi] & carry[gi];
        end
    endgenerate

    assign cout = carry[N];

endmodule

// File: rtl/inc_sequencer.sv
// Multi-cycle sequencer that applies the incrementer req_count times to the
// selected operand and returns the result with sticky-carry and zero flags.
module inc_sequencer
    import inc_sequencer_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    inc_sequencer_if.slave     bus
);

    state_t           state_reg, state_next;
    logic [N-1:0]     acc_reg, acc_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic             sticky_reg, sticky_next;
    logic [N-1:0]     res_y_reg, res_y_next;
    logic             res_cout_reg, res_cout_next;
    logic             res_zero_reg, res_zero_next;

    logic [N-1:0]     inc_y;
    logic             inc_cout;

    inc_unit #(.N(N)) u_inc (
        .a    (acc_reg),
        .y    (inc_y),
        .cout (inc_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            remaining_reg <= '0;
            sticky_reg    <= 1'b0;
            res_y_reg     <= '0;
            res_cout_reg  <= 1'b0;
            res_zero_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            remaining_reg <= remaining_next;
            sticky_reg    <= sticky_next;
            res_y_reg     <= res_y_next;
            res_cout_reg  <= res_cout_next;
            res_zero_reg  <= res_zero_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        remaining_next = remaining_reg;
        sticky_next    = sticky_reg;
        res_y_next     = res_y_reg;
        res_cout_next  = res_cout_reg;
        res_zero_next  = res_zero_reg;

        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    acc_next       = (bus.req_sel == SEL_B) ? bus.req_b : bus.req_a;
                    remaining_next = bus.req_count;
                    sticky_next    = 1'b0;
                    state_next     = (bus.req_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    acc_next       = inc_y;
                    sticky_next    = sticky_reg | inc_cout;
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // abort and a result handshake both retire the transaction
                if (bus.abort || bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Result registers load only on entry to DONE, so they hold through IDLE/RUN.
        if (state_next == DONE && state_reg != DONE) begin
            res_y_next    = acc_next;
            res_cout_next = sticky_next;
            res_zero_next = (acc_next == '0);
        end
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.busy      = (state_reg == RUN);
    assign bus.res_valid = (state_reg == DONE);
    assign bus.res_y     = res_y_reg;
    assign bus.res_cout  = res_cout_reg;
    assign bus.res_zero  = res_zero_reg;

endmodule

// File: tb/tb_inc_sequencer.sv
// Scoreboard bench for inc_sequencer: directed scenarios plus random
// transactions, expected results from an arithmetic reference model.
module tb_inc_sequencer;

    localparam int N     = 4;
    localparam int CNT_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    inc_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

    inc_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] y;
        logic         cout;
        logic         zero;
        int           count;
        int           accept_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: count increments of op are simply op + count, reduced mod 2^N.
    function automatic exp_t model(input logic [N-1:0] op, input int count, input int acc_cyc);
        exp_t e;
        int   total;
        total        = int'(op) + count;
        e.y          = N'(total % (1 << N));
        e.cout       = (total >= (1 << N));
        e.zero       = ((total % (1 << N)) == 0);
        e.count      = count;
        e.accept_cyc = acc_cyc;
        return e;
    endfunction

    // Monitor: compares every cycle a result is presented, pops on handshake.
    initial begin
        int   busy_cnt;
        bit   prev_valid;
        exp_t e;
        busy_cnt   = 0;
        prev_valid = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt   = 0;
                prev_valid = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.req_ready) busy_cnt = 0;
                if (bus.res_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: actual res_y=%0h required no result (cycle %0d)",
                                 bus.res_y, cyc);
                    end else begin
                        e = exp_q[0];
                        if (!prev_valid) begin
                            check("latency", 32'(cyc - e.accept_cyc), 32'(e.count));
                            check("busy_cycles", 32'(busy_cnt), 32'(e.count));
                        end
                        check("res_y", 32'(bus.res_y), 32'(e.y));
                        check("res_cout", 32'(bus.res_cout), 32'(e.cout));
                        check("res_zero", 32'(bus.res_zero), 32'(e.zero));
                        check("req_ready_in_done", 32'(bus.req_ready), 32'd0);
                        check("busy_in_done", 32'(bus.busy), 32'd0);
                        if (bus.res_ready && !bus.abort) void'(exp_q.pop_front());
                    end
                end
                prev_valid = bus.res_valid;
            end
        end
    end

    task automatic send(input logic sel, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [CNT_W-1:0] cnt, input bit expect_res);
        int guard;
        guard = 0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_sel   = sel;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_count = cnt;
        @(negedge clk);
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: actual req_ready=0 required 1 within 50 cycles");
        end else if (expect_res) begin
            exp_q.push_back(model(sel ? b : a, int'(cnt), cyc + 1));
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic collect(input int hold);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.res_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.res_valid) begin
            checks++;
            failures++;
            $display("FAIL result_timeout: actual res_valid=0 required 1 within 100 cycles");
            return;
        end
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        check("req_ready_after_handshake", 32'(bus.req_ready), 32'd1);
        check("res_valid_after_handshake", 32'(bus.res_valid), 32'd0);
    endtask

    task automatic abort_after(input int k);
        repeat (k) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        check("req_ready_after_abort", 32'(bus.req_ready), 32'd1);
        check("res_valid_after_abort", 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: actual simulation still running required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_sel   = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_count = '0;
        bus.abort     = 1'b0;
        bus.res_ready = 1'b0;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_y", 32'(bus.res_y), 32'd0);
        check("rst_res_cout", 32'(bus.res_cout), 32'd0);
        check("rst_res_zero", 32'(bus.res_zero), 32'd0);
        rst_n = 1'b1;

        // Pass-through, wrap with carry, zero via B
        send(1'b0, 4'h5, 4'h0, 4'd0, 1'b1);  collect(0);
        $display("txn pass-through a=5 count=0");
        send(1'b0, 4'hE, 4'h0, 4'd3, 1'b1);  collect(1);
        $display("txn wrap a=E count=3");
        send(1'b1, 4'h3, 4'hF, 4'd1, 1'b1);  collect(0);
        $display("txn zero-via-b b=F count=1");

        // Backpressure: five cycles of valid without ready
        send(1'b0, 4'h2, 4'h0, 4'd2, 1'b1);  collect(4);
        $display("txn backpressure a=2 count=2 hold=5");

        // Abort in the 4th RUN cycle while a second request waits
        send(1'b0, 4'h0, 4'h0, 4'd15, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_sel   = 1'b0;
        bus.req_a     = 4'h9;
        bus.req_count = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_while_req_pending", 32'(bus.busy), 32'd1);
            @(posedge clk);
        end
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        check("req_ready_after_abort", 32'(bus.req_ready), 32'd1);
        check("res_valid_after_abort", 32'(bus.res_valid), 32'd0);
        exp_q.push_back(model(4'h9, 0, cyc + 1));
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        collect(1);
        $display("txn abort a=0 count=15 then held request a=9 accepted");

        // Asynchronous reset in the middle of RUN
        send(1'b0, 4'h0, 4'h0, 4'd15, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("async_rst_res_y", 32'(bus.res_y), 32'd0);
        check("async_rst_res_cout", 32'(bus.res_cout), 32'd0);
        check("async_rst_res_zero", 32'(bus.res_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 4'h7, 4'h0, 4'd1, 1'b1);  collect(0);
        $display("txn async reset mid-run, then a=7 count=1");

        for (int t = 0; t < 40; t++) begin
            logic             sel;
            logic [N-1:0]     a;
            logic [N-1:0]     b;
            logic [CNT_W-1:0] cnt;
            int               k;
            sel = 1'($urandom_range(0, 1));
            a   = N'($urandom);
            b   = N'($urandom);
            cnt = CNT_W'($urandom_range(0, 15));
            if (cnt != 0 && $urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, int'(cnt) - 1);
                send(sel, a, b, cnt, 1'b0);
                abort_after(k);
                $display("txn random %0d sel=%0d a=%0h b=%0h count=%0d aborted after %0d", t, sel, a, b, cnt, k + 1);
            end else begin
                send(sel, a, b, cnt, 1'b1);
                collect($urandom_range(0, 3));
                $display("txn random %0d sel=%0d a=%0h b=%0h count=%0d", t, sel, a, b, cnt);
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
